// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared state encoding, busy ignore length and address width helper
package adc_sched_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CNV        = 3'd1,
        BUSY       = 3'd2,
        SPI        = 3'd3,
        WAIT_VALID = 3'd4,
        STORE      = 3'd5
    } state_e;

    localparam int BUSY_IGNORE = 2;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/adc_conv_scheduler_if.sv
// adc_conv_scheduler_if: ADC strobe/busy/valid handshakes and DPBRAM write port
interface adc_conv_scheduler_if #(
    parameter int AW = 15
);
    logic          cnv;
    logic          spi_start;
    logic          dc_start;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          v_busy;
    logic          c_busy;
    logic          v_valid;
    logic          c_valid;

    modport master (
        output cnv, spi_start, dc_start, ram_we, ram_addr,
        input  v_busy, c_busy, v_valid, c_valid
    );

    modport slave (
        input  cnv, spi_start, dc_start, ram_we, ram_addr,
        output v_busy, c_busy, v_valid, c_valid
    );
endinterface

// File: rtl/adc_period_timer.sv
// adc_period_timer: free-running frame counter gated by enable, tick at count 0
module adc_period_timer #(
    parameter int CONV_PERIOD = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (!i_en || cnt_q == CW'(CONV_PERIOD - 1)) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_tick = i_en && cnt_q == '0;
endmodule

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: per-frame ADC conversion, SPI readout and ping-pong DPBRAM write sequencing
module adc_conv_scheduler
    import adc_sched_pkg::*;
#(
    parameter int CONV_PERIOD  = 100,
    parameter int CNV_HIGH     = 4,
    parameter int BUSY_TIMEOUT = 64,
    parameter int RAM_DEPTH    = 20000,
    parameter int DC_DIV       = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [1:0]            i_flag_clr,
    adc_conv_scheduler_if.master  bus,
    output logic [1:0]            o_half_flag,
    output logic                  o_timeout,
    output logic                  o_overrun,
    output logic [2:0]            o_state
);
    localparam int AW = addr_w(RAM_DEPTH);
    localparam int FW = addr_w(DC_DIV);
    localparam logic [15:0] CNV_LAST   = 16'(CNV_HIGH - 1);
    localparam logic [15:0] BUSY_FIRST = 16'(BUSY_IGNORE);
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_IGNORE + BUSY_TIMEOUT - 1);
    localparam logic [15:0] VALID_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(RAM_DEPTH - 1);
    localparam logic [AW-1:0] ADDR_HALF = AW'(RAM_DEPTH / 2 - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(DC_DIV - 1);

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          v_lat_q, v_lat_d, c_lat_q, c_lat_d;
    logic          cnv_q, cnv_d, spi_q, spi_d, we_q, we_d, dc_q, dc_d;
    logic          to_q, to_d, ov_q, ov_d;
    logic [1:0]    flag_q, flag_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          tick, v_seen, c_seen;

    adc_period_timer #(.CONV_PERIOD(CONV_PERIOD)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .o_tick (tick)
    );

    assign v_seen = v_lat_q | bus.v_valid;
    assign c_seen = c_lat_q | bus.c_valid;

    // Outputs are computed one cycle ahead so every strobe leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        v_lat_d = v_lat_q;
        c_lat_d = c_lat_q;
        cnv_d   = 1'b0;
        spi_d   = 1'b0;
        we_d    = 1'b0;
        dc_d    = 1'b0;
        to_d    = to_q;
        ov_d    = ov_q | (tick && state_q != IDLE);
        addr_d  = addr_q;
        fcnt_d  = fcnt_q;
        flag_d  = flag_q & ~i_flag_clr;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CNV;
                    cnv_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            CNV: begin
                cnv_d = cnt_q != CNV_LAST;
                if (cnt_q == CNV_LAST) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q >= BUSY_FIRST && !bus.v_busy && !bus.c_busy) begin
                    state_d = SPI;
                    spi_d   = 1'b1;
                end else if (cnt_q == BUSY_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
            SPI: begin
                state_d = WAIT_VALID;
                cnt_d   = '0;
            end
            WAIT_VALID: begin
                v_lat_d = v_seen;
                c_lat_d = c_seen;
                if (v_seen && c_seen) begin
                    state_d = STORE;
                    we_d    = 1'b1;
                    dc_d    = fcnt_q == FRAME_LAST;
                end else if (cnt_q == VALID_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    v_lat_d = 1'b0;
                    c_lat_d = 1'b0;
                end
            end
            STORE: begin
                state_d = IDLE;
                v_lat_d = 1'b0;
                c_lat_d = 1'b0;
                addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                fcnt_d  = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + 1'b1;
                flag_d  = flag_d | {addr_q == ADDR_LAST, addr_q == ADDR_HALF};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v_lat_q <= 1'b0;
            c_lat_q <= 1'b0;
            cnv_q   <= 1'b0;
            spi_q   <= 1'b0;
            we_q    <= 1'b0;
            dc_q    <= 1'b0;
            to_q    <= 1'b0;
            ov_q    <= 1'b0;
            flag_q  <= '0;
            addr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_lat_q <= v_lat_d;
            c_lat_q <= c_lat_d;
            cnv_q   <= cnv_d;
            spi_q   <= spi_d;
            we_q    <= we_d;
            dc_q    <= dc_d;
            to_q    <= to_d;
            ov_q    <= ov_d;
            flag_q  <= flag_d;
            addr_q  <= addr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.cnv       = cnv_q;
    assign bus.spi_start = spi_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.dc_start  = dc_q;
    assign o_half_flag   = flag_q;
    assign o_timeout     = to_q;
    assign o_overrun     = ov_q;
    assign o_state       = state_q;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: directed frames against hand-computed timing, addresses and flags
module tb_adc_conv_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] flag_clr = 2'b00;
    logic [1:0] half_flag;
    logic       timeout, overrun;
    logic [2:0] state;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         we_cnt = 0;
    int         dc_cnt = 0;
    int         exp_addr = 0;
    int         last_rise = 0;
    int         prev_rise = 0;

    adc_conv_scheduler_if #(.AW(3)) bus ();

    adc_conv_scheduler #(
        .CONV_PERIOD  (100),
        .CNV_HIGH     (4),
        .BUSY_TIMEOUT (64),
        .RAM_DEPTH    (8),
        .DC_DIV       (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_flag_clr  (flag_clr),
        .bus         (bus),
        .o_half_flag (half_flag),
        .o_timeout   (timeout),
        .o_overrun   (overrun),
        .o_state     (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.ram_we) we_cnt <= we_cnt + 1;
        if (bus.dc_start) dc_cnt <= dc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // busy_lo < 0 leaves busy stuck high; valid offsets count clocks after the spi_start cycle
    task automatic frame(input string tag, input int busy_lo, input int v_off, input int c_off,
                         input bit exp_dc, input bit clr_on_we);
        int n;
        int t_fall;
        int we0;
        int last;
        n = 0;
        while (!bus.cnv && n < 400) begin @(negedge clk); n++; end
        chk({tag, "_cnv_rise"}, 32'(bus.cnv), 1);
        prev_rise = last_rise;
        last_rise = cyc;
        bus.v_busy = 1'b1;
        bus.c_busy = 1'b1;
        n = 0;
        while (bus.cnv && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_cnv_width"}, n, 4);
        t_fall = cyc;
        we0 = we_cnt;
        if (busy_lo < 0) begin
            repeat (65) @(negedge clk);
            chk({tag, "_to_early"}, 32'(timeout), 0);
            @(negedge clk);
            chk({tag, "_to_set"}, 32'(timeout), 1);
            chk({tag, "_to_idle"}, 32'(state), 0);
            bus.v_busy = 1'b0;
            bus.c_busy = 1'b0;
            repeat (5) @(negedge clk);
            chk({tag, "_to_nowrite"}, we_cnt, we0);
            chk({tag, "_to_addr"}, 32'(bus.ram_addr), exp_addr);
        end else begin
            repeat (busy_lo) @(negedge clk);
            bus.v_busy = 1'b0;
            bus.c_busy = 1'b0;
            n = 0;
            while (!bus.spi_start && n < 200) begin @(negedge clk); n++; end
            chk({tag, "_spi_lat"}, cyc - t_fall, (busy_lo < 2 ? 2 : busy_lo) + 1);
            last = v_off > c_off ? v_off : c_off;
            for (int k = 1; k <= last; k++) begin
                @(negedge clk);
                if (k == 1) chk({tag, "_spi_width"}, 32'(bus.spi_start), 0);
                bus.v_valid = (k == v_off);
                bus.c_valid = (k == c_off);
            end
            @(negedge clk);
            bus.v_valid = 1'b0;
            bus.c_valid = 1'b0;
            chk({tag, "_we"}, 32'(bus.ram_we), 1);
            chk({tag, "_we_addr"}, 32'(bus.ram_addr), exp_addr);
            chk({tag, "_dc"}, 32'(bus.dc_start), 32'(exp_dc));
            if (clr_on_we) flag_clr = 2'b01;
            @(negedge clk);
            flag_clr = 2'b00;
            exp_addr = (exp_addr + 1) % 8;
            chk({tag, "_we_width"}, 32'(bus.ram_we), 0);
            chk({tag, "_addr_next"}, 32'(bus.ram_addr), exp_addr);
            chk({tag, "_one_write"}, we_cnt - we0, 1);
        end
    endtask

    initial begin
        int n;
        bus.v_busy = 1'b0;
        bus.c_busy = 1'b0;
        bus.v_valid = 1'b0;
        bus.c_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cnv", 32'(bus.cnv), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_addr", 32'(bus.ram_addr), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_flags", 32'(half_flag), 0);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        frame("nom1", 40, 30, 30, 1'b0, 1'b0);
        chk("nom1_timeout", 32'(timeout), 0);
        chk("nom1_overrun", 32'(overrun), 0);
        frame("nom2", 40, 30, 30, 1'b0, 1'b0);
        chk("period_100", last_rise - prev_rise, 100);
        frame("skew", 10, 10, 25, 1'b1, 1'b0);
        chk("flags_before_half", 32'(half_flag), 0);
        frame("stuck", -1, 0, 0, 1'b0, 1'b0);
        frame("half", 5, 5, 5, 1'b0, 1'b1);
        chk("half_set_wins", 32'(half_flag), 1);
        chk("pre_overrun", 32'(overrun), 0);
        frame("ovr", 55, 50, 50, 1'b0, 1'b0);
        chk("overrun_set", 32'(overrun), 1);
        frame("after_ovr", 20, 10, 10, 1'b1, 1'b0);
        chk("period_dropped_tick", last_rise - prev_rise, 200);
        frame("f8", 20, 10, 10, 1'b0, 1'b0);
        frame("f9", 20, 10, 10, 1'b0, 1'b0);
        chk("both_flags", 32'(half_flag), 3);
        chk("addr_wrapped", 32'(bus.ram_addr), 0);
        chk("dc_pulses", dc_cnt, 2);
        flag_clr = 2'b01;
        @(negedge clk);
        flag_clr = 2'b10;
        chk("clr_first", 32'(half_flag), 2);
        @(negedge clk);
        flag_clr = 2'b00;
        chk("clr_second", 32'(half_flag), 0);
        n = 0;
        while (!bus.cnv && n < 400) begin @(negedge clk); n++; end
        bus.v_busy = 1'b1;
        bus.c_busy = 1'b1;
        repeat (6) @(negedge clk);
        bus.v_busy = 1'b0;
        bus.c_busy = 1'b0;
        n = 0;
        while (!bus.spi_start && n < 200) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        bus.v_valid = 1'b1;
        @(negedge clk);
        bus.v_valid = 1'b0;
        chk("mid_wait_state", 32'(state), 4);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_state", 32'(state), 0);
        chk("mrst_cnv", 32'(bus.cnv), 0);
        chk("mrst_spi", 32'(bus.spi_start), 0);
        chk("mrst_we", 32'(bus.ram_we), 0);
        chk("mrst_dc", 32'(bus.dc_start), 0);
        chk("mrst_timeout", 32'(timeout), 0);
        chk("mrst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        en = 1'b0;
        bus.c_valid = 1'b1;
        @(negedge clk);
        bus.c_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_no_write", 32'(bus.ram_we), 0);
        chk("mrst_state_idle", 32'(state), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
